// File: rtl/ex_mem_stage.sv
// ============================================================================
// ex_mem_stage : EX/MEM pipeline register with flag register, branch decision
//                and MEM->EX forwarding detect.          Rev 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage #(
  parameter int WIDTH = 64,
  parameter int RW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] store_data,
  input  logic [RW-1:0]    rd,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             is_blt,
  input  logic             is_cbz,
  input  logic [RW-1:0]    rs_a,
  input  logic [RW-1:0]    rs_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_store_data,
  output logic [RW-1:0]    out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_c,
  output logic             take_branch,
  output logic             fwd_a,
  output logic             fwd_b
);

  localparam logic [RW-1:0] c_XZR = RW'(31);

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_store_data;
  logic [RW-1:0]    r_rd;
  logic             r_reg_write;
  logic             r_mem_read;
  logic             r_mem_write;
  logic [3:0]       r_flags;    // {N, Z, V, C}

  logic w_load;
  logic w_mem_writes_reg;

  assign w_load = ~stall & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_flags      <= 4'b0000;
    end else if (flush) begin
      // Squash only the control side; data fields are don't-care when invalid.
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (w_load) begin
      r_valid      <= in_valid;
      r_result     <= alu_result;
      r_store_data <= store_data;
      r_rd         <= rd;
      r_reg_write  <= in_valid & reg_write;
      r_mem_read   <= in_valid & mem_read;
      r_mem_write  <= in_valid & mem_write;
      if (in_valid && set_flags) begin
        r_flags <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
      end
    end
  end

  assign out_valid      = r_valid;
  assign out_result     = r_result;
  assign out_store_data = r_store_data;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_reg_write;
  assign out_mem_read   = r_mem_read;
  assign out_mem_write  = r_mem_write;
  assign flag_n         = r_flags[3];
  assign flag_z         = r_flags[2];
  assign flag_v         = r_flags[1];
  assign flag_c         = r_flags[0];

  // B.LT reads the committed flags, never the flags this instruction produces.
  assign take_branch = in_valid & ~flush &
                       ((is_blt & (r_flags[3] ^ r_flags[1])) | (is_cbz & alu_zero));

  assign w_mem_writes_reg = r_valid & r_reg_write & (r_rd != c_XZR);
  assign fwd_a            = w_mem_writes_reg & (r_rd == rs_a);
  assign fwd_b            = w_mem_writes_reg & (r_rd == rs_b);

endmodule

`default_nettype wire
